// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_pkg
// Description : Shared types and constants for the multi-cycle shift
//               sequencer: FSM states, operation codes, stage indexing.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Shift operation codes
   localparam logic OP_SLL = 1'b0;   // logical left, zero fill
   localparam logic OP_SRA = 1'b1;   // arithmetic right, sign fill

   // Number of power-of-two stages (16, 8, 4, 2, 1)
   localparam int STAGE_COUNT = 5;

   // Stage index; three bits cover indices 0..4
   localparam int STAGE_IDX_W = 3;
   typedef logic [STAGE_IDX_W-1:0] stage_idx_t;

endpackage : shift_seq_pkg
`default_nettype wire

// File: rtl/shift_stage_mux.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage_mux
// Description : Combinational single-stage shifter. Applies (or bypasses) a
//               shift of 2^stage positions, left with zero fill or right
//               with sign fill, to the incoming work value.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage_mux
   import shift_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] work_in,
   input  stage_idx_t            stage,
   input  logic                  apply,
   input  logic                  op,
   output logic [DATA_WIDTH-1:0] work_out
);

   localparam int NUM_SLOTS = 1 << STAGE_IDX_W;

   // One fixed-distance shifter per index; unused indices pass the value
   // through so every stage-index value selects something well defined.
   logic [DATA_WIDTH-1:0] w_shl [NUM_SLOTS];
   logic [DATA_WIDTH-1:0] w_sra [NUM_SLOTS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_stage
         if (gi < STAGE_COUNT) begin : g_real
            assign w_shl[gi] = work_in << (1 << gi);
            assign w_sra[gi] = $signed(work_in) >>> (1 << gi);
         end else begin : g_pad
            assign w_shl[gi] = work_in;
            assign w_sra[gi] = work_in;
         end
      end
   endgenerate

   // Select the shifted value for this stage, or bypass when not applied
   always_comb begin
      work_out = work_in;
      if (apply) begin
         work_out = (op == OP_SRA) ? w_sra[stage] : w_shl[stage];
      end
   end

endmodule : shift_stage_mux
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle SLL/SRA controller. Latches one request, then
//               walks the operand through the 16/8/4/2/1 stages, one stage
//               per clock, and pulses data_resultRDY for one cycle at the end.
//               Fixed latency of five shift cycles regardless of shamt.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ctrl_start,
   input  logic                   ctrl_op,
   input  logic [DATA_WIDTH-1:0]  data_operandA,
   input  logic [SHAMT_WIDTH-1:0] ctrl_shiftamt,
   output logic [DATA_WIDTH-1:0]  data_result,
   output logic                   data_resultRDY,
   output logic                   busy
);

   state_e                 state_q,       state_d;
   logic [DATA_WIDTH-1:0]  work_q,        work_d;
   logic [SHAMT_WIDTH-1:0] shamt_q,       shamt_d;
   logic                   op_q,          op_d;
   stage_idx_t             stage_q,       stage_d;
   logic [DATA_WIDTH-1:0]  data_result_q, data_result_d;

   logic [DATA_WIDTH-1:0]  w_next_work;

   // One stage of the shift applied to the current work value
   shift_stage_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stage_mux (
      .work_in  (work_q),
      .stage    (stage_q),
      .apply    (shamt_q[stage_q]),
      .op       (op_q),
      .work_out (w_next_work)
   );

   // Next-state and datapath control; DONE accepts like IDLE for back-to-back
   always_comb begin
      state_d       = state_q;
      work_d        = work_q;
      shamt_d       = shamt_q;
      op_d          = op_q;
      stage_d       = stage_q;
      data_result_d = data_result_q;

      case (state_q)
         IDLE, DONE: begin
            if (ctrl_start) begin
               work_d  = data_operandA;
               shamt_d = ctrl_shiftamt;
               op_d    = ctrl_op;
               stage_d = stage_idx_t'(STAGE_COUNT - 1);
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            work_d = w_next_work;
            if (stage_q == '0) begin
               data_result_d = w_next_work;
               state_d       = DONE;
            end else begin
               stage_d = stage_q - stage_idx_t'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-operand registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         work_q        <= '0;
         shamt_q       <= '0;
         op_q          <= 1'b0;
         stage_q       <= '0;
         data_result_q <= '0;
      end else begin
         state_q       <= state_d;
         work_q        <= work_d;
         shamt_q       <= shamt_d;
         op_q          <= op_d;
         stage_q       <= stage_d;
         data_result_q <= data_result_d;
      end
   end

   assign data_result    = data_result_q;
   assign data_resultRDY = (state_q == DONE);
   assign busy           = (state_q == SHIFT);

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer. Directed scenarios
//               plus randomized requests compared against an arithmetic
//               reference of the shift operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_start;
   logic        ctrl_op;
   logic [31:0] data_operandA;
   logic [4:0]  ctrl_shiftamt;
   logic [31:0] data_result;
   logic        data_resultRDY;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   shift_sequencer #(
      .DATA_WIDTH  (32),
      .SHAMT_WIDTH (5)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_start     (ctrl_start),
      .ctrl_op        (ctrl_op),
      .data_operandA  (data_operandA),
      .ctrl_shiftamt  (ctrl_shiftamt),
      .data_result    (data_result),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   // Reference: the whole shift in one arithmetic step
   function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                             input logic [4:0] s,
                                             input logic op);
      if (op) return 32'($signed(a) >>> s);
      else    return a << s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; request pulse ends after the edge; land on negedge
   task automatic tick();
      @(posedge clock);
      #1 ctrl_start = 1'b0;
      @(negedge clock);
   endtask

   task automatic issue(input logic [31:0] a, input logic [4:0] s,
                        input logic op);
      ctrl_start    = 1'b1;
      data_operandA = a;
      ctrl_shiftamt = s;
      ctrl_op       = op;
   endtask

   // Issue at current negedge, check five busy cycles, end in the DONE cycle
   task automatic run_check(input string tag, input logic [31:0] a,
                            input logic [4:0] s, input logic op,
                            input logic [31:0] exp);
      issue(a, s, op);
      tick();
      // Scramble the inputs: latched values must not be affected
      data_operandA = $urandom;
      ctrl_shiftamt = 5'($urandom);
      ctrl_op       = 1'($urandom);
      for (int i = 0; i < 5; i++) begin
         chk({tag, " busy"}, 32'(busy), 32'd1);
         if (data_resultRDY) chk({tag, " early rdy"}, 32'(data_resultRDY), 32'd0);
         tick();
      end
      chk({tag, " rdy"},    32'(data_resultRDY), 32'd1);
      chk({tag, " busy_done"}, 32'(busy), 32'd0);
      chk({tag, " result"}, data_result, exp);
      chk({tag, " model"},  data_result, ref_shift(a, s, op));
   endtask

   initial begin
      int pulses;
      logic [31:0] a;
      logic [4:0]  s;
      logic        op;

      reset         = 1'b1;
      ctrl_start    = 1'b0;
      ctrl_op       = 1'b0;
      data_operandA = '0;
      ctrl_shiftamt = '0;

      // Reset for two cycles
      @(negedge clock);
      tick();
      tick();
      reset = 1'b0;
      chk("reset result", data_result, 32'h0);
      chk("reset rdy", 32'(data_resultRDY), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (data_resultRDY || busy) pulses++;
      end
      chk("idle quiet", 32'(pulses), 32'd0);

      // Directed vectors
      run_check("sll1x4", 32'h0000_0001, 5'd4, 1'b0, 32'h0000_0010);
      tick();
      chk("rdy single", 32'(data_resultRDY), 32'd0);
      run_check("sra31", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
      tick();
      run_check("sra4", 32'h7FFF_FFF0, 5'd4, 1'b1, 32'h07FF_FFFF);
      tick();
      run_check("sll0", 32'hFFFF_FFFF, 5'd0, 1'b0, 32'hFFFF_FFFF);
      tick();

      // Start during the 2nd SHIFT cycle is ignored
      issue(32'h0000_00F0, 5'd2, 1'b0);
      tick();
      tick();
      issue(32'h1234_5678, 5'd7, 1'b1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (data_resultRDY) begin
            pulses++;
            chk("ignore result", data_result, 32'h0000_03C0);
         end
      end
      chk("ignore pulses", 32'(pulses), 32'd1);
      chk("ignore idle busy", 32'(busy), 32'd0);

      // Back-to-back: second request accepted in the DONE cycle
      run_check("b2b_a", 32'hA5A5_0000, 5'd8, 1'b1, 32'hFFA5_A500);
      run_check("b2b_b", 32'h0000_0003, 5'd1, 1'b0, 32'h0000_0006);
      tick();
      chk("b2b end rdy", 32'(data_resultRDY), 32'd0);

      // Reset during the 3rd SHIFT cycle aborts the operation
      issue(32'h0000_0001, 5'd5, 1'b0);
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort rdy", 32'(data_resultRDY), 32'd0);
      chk("abort result", data_result, 32'h0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (data_resultRDY) pulses++;
      end
      chk("abort no pulse", 32'(pulses), 32'd0);
      run_check("post_abort", 32'h0000_0001, 5'd5, 1'b0, 32'h0000_0020);
      tick();

      // Reset and start on the same edge: request dropped
      reset = 1'b1;
      issue(32'hDEAD_BEEF, 5'd3, 1'b0);
      tick();
      reset = 1'b0;
      chk("rst+start busy", 32'(busy), 32'd0);
      tick();
      chk("rst+start busy2", 32'(busy), 32'd0);

      // Randomized requests, some back-to-back
      for (int n = 0; n < 24; n++) begin
         a  = $urandom;
         s  = 5'($urandom_range(0, 31));
         op = 1'($urandom);
         run_check("rand", a, s, op, ref_shift(a, s, op));
         if ($urandom_range(0, 1) == 0) begin
            tick();
            chk("rand rdy drop", 32'(data_resultRDY), 32'd0);
         end
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_shift_sequencer
`default_nettype wire
